// File: rtl/traffic_phase_controller_if.sv
// traffic_phase_controller_if: run-control bundle between the
// load-test sources/sinks and the phase controller.
interface traffic_phase_controller_if #(
  parameter int unsigned PORTS = 16
);
  logic             start;
  logic [PORTS-1:0] inj_valid;
  logic [PORTS-1:0] ej_valid;
  logic [PORTS-1:0] ej_measure;
  logic [PORTS-1:0] fifo_error;

  logic             src_enable;
  logic             measure;
  logic [23:0]      timestamp;
  logic [2:0]       phase;
  logic             done;
  logic             drain_timeout;
  logic             overflow_err;
  logic [31:0]      total_in;
  logic [31:0]      meas_in;
  logic [31:0]      meas_out;
  logic [31:0]      meas_cycles;

  modport master (
    output start,
    output inj_valid,
    output ej_valid,
    output ej_measure,
    output fifo_error,
    input  src_enable,
    input  measure,
    input  timestamp,
    input  phase,
    input  done,
    input  drain_timeout,
    input  overflow_err,
    input  total_in,
    input  meas_in,
    input  meas_out,
    input  meas_cycles
  );

  modport slave (
    input  start,
    input  inj_valid,
    input  ej_valid,
    input  ej_measure,
    input  fifo_error,
    output src_enable,
    output measure,
    output timestamp,
    output phase,
    output done,
    output drain_timeout,
    output overflow_err,
    output total_in,
    output meas_in,
    output meas_out,
    output meas_cycles
  );
endinterface

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: sequences a load-test run
// IDLE -> WARMUP -> MEASURE -> DRAIN -> DONE with packet accounting.
module traffic_phase_controller #(
  parameter int unsigned PORTS         = 16,
  parameter int unsigned WARMUP_PKTS   = 2000,
  parameter int unsigned MEASURE_PKTS  = 20000,
  parameter int unsigned DRAIN_TIMEOUT = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  traffic_phase_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_MEASURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } phase_e;

  phase_e      state_q, state_d;
  logic [23:0] ts_q, ts_d;
  logic [31:0] total_q, total_d;
  logic [31:0] min_q, min_d;
  logic [31:0] mout_q, mout_d;
  logic [31:0] mcyc_q, mcyc_d;
  logic [31:0] timer_q, timer_d;
  logic        dto_q, dto_d;
  logic        ovf_q, ovf_d;
  logic        src_en_q, src_en_d;
  logic        meas_q, meas_d;
  logic        done_q, done_d;

  logic [31:0] pop_inj;
  logic [31:0] pop_ej;
  logic        active;
  logic        timeout_hit;

  // Popcounts of this cycle's injections and measured ejections.
  always_comb begin
    pop_inj = '0;
    pop_ej  = '0;
    for (int i = 0; i < int'(PORTS); i++) begin
      pop_inj = pop_inj + 32'(bus.inj_valid[i]);
      pop_ej  = pop_ej
              + 32'(bus.ej_valid[i] & bus.ej_measure[i]);
    end
  end

  assign active = (state_q == S_WARMUP)
               || (state_q == S_MEASURE)
               || (state_q == S_DRAIN);

  // Timer counts from 0 on DRAIN entry; the cycle holding
  // DRAIN_TIMEOUT-1 is the last one spent in DRAIN.
  assign timeout_hit =
    ({1'b0, timer_q} + 33'd1) >= 33'(DRAIN_TIMEOUT);

  // Next phase and next value of every counter and flag.
  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    total_d = total_q;
    min_d   = min_q;
    mout_d  = mout_q;
    mcyc_d  = mcyc_q;
    timer_d = timer_q;
    dto_d   = dto_q;
    ovf_d   = ovf_q;

    if (active) begin
      ts_d    = ts_q + 24'd1;
      total_d = total_q + pop_inj;
      if (|bus.fifo_error)
        ovf_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_WARMUP;
          ts_d    = '0;
          total_d = '0;
          min_d   = '0;
          mout_d  = '0;
          mcyc_d  = '0;
          timer_d = '0;
          dto_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_WARMUP: begin
        if (total_d >= WARMUP_PKTS)
          state_d = S_MEASURE;
      end
      S_MEASURE: begin
        min_d  = min_q + pop_inj;
        mcyc_d = mcyc_q + 32'd1;
        mout_d = mout_q + pop_ej;
        if (min_d >= MEASURE_PKTS) begin
          state_d = S_DRAIN;
          timer_d = '0;
        end
      end
      S_DRAIN: begin
        mout_d  = mout_q + pop_ej;
        timer_d = timer_q + 32'd1;
        if (mout_d >= min_q) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
          dto_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    src_en_d = (state_d == S_WARMUP)
            || (state_d == S_MEASURE)
            || (state_d == S_DRAIN);
    meas_d   = (state_d == S_MEASURE);
    done_d   = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ts_q     <= '0;
      total_q  <= '0;
      min_q    <= '0;
      mout_q   <= '0;
      mcyc_q   <= '0;
      timer_q  <= '0;
      dto_q    <= 1'b0;
      ovf_q    <= 1'b0;
      src_en_q <= 1'b0;
      meas_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      total_q  <= total_d;
      min_q    <= min_d;
      mout_q   <= mout_d;
      mcyc_q   <= mcyc_d;
      timer_q  <= timer_d;
      dto_q    <= dto_d;
      ovf_q    <= ovf_d;
      src_en_q <= src_en_d;
      meas_q   <= meas_d;
      done_q   <= done_d;
    end
  end

  assign bus.phase         = state_q;
  assign bus.timestamp     = ts_q;
  assign bus.total_in      = total_q;
  assign bus.meas_in       = min_q;
  assign bus.meas_out      = mout_q;
  assign bus.meas_cycles   = mcyc_q;
  assign bus.drain_timeout = dto_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.src_enable    = src_en_q;
  assign bus.measure       = meas_q;
  assign bus.done          = done_q;

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Sequences a load-test run for all packet sources: idle, warm-up, measurement, drain, done.
- Drives the shared timestamp, the global source-enable, and the measure tag that sources copy into each packet.
- Counts injected and ejected measured packets across all ports.
- Declares the run complete once every measured packet has left the network, or when the drain timeout expires.

Parameters:
- PORTS, 16: number of source/sink ports.
- WARMUP_PKTS, 2000: total injected packets before measurement starts.
- MEASURE_PKTS, 20000: measured packets to inject.
- DRAIN_TIMEOUT, 65535: maximum cycles spent in DRAIN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request pulse; accepted only in IDLE or DONE.
- inj_valid  in  PORTS  per-port packet injected this cycle.
- ej_valid  in  PORTS  per-port packet ejected this cycle.
- ej_measure  in  PORTS  measure bit of the ejected packet, qualified by ej_valid.
- fifo_error  in  PORTS  per-port source input-FIFO full.
- src_enable  out  1  sources may generate packets.
- measure  out  1  tag value for packets injected this cycle.
- timestamp  out  24  run-time cycle count.
- phase  out  3  0 IDLE, 1 WARMUP, 2 MEASURE, 3 DRAIN, 4 DONE.
- done  out  1  high in DONE.
- drain_timeout  out  1  sticky; DONE was reached by timeout.
- overflow_err  out  1  sticky; any fifo_error seen during a run.
- total_in  out  32  all packets injected this run.
- meas_in  out  32  measured packets injected.
- meas_out  out  32  measured packets ejected.
- meas_cycles  out  32  cycles spent in MEASURE.

Behaviour:
- Reset: phase=IDLE. All outputs and counters are 0, including the sticky flags.
- All outputs are registered.
- Per-cycle increments use the popcount of the relevant vector (0..PORTS), computed combinationally. Counters are 32-bit and wrap.
- IDLE: src_enable=0, measure=0, timestamp held at 0.
  - start=1 → WARMUP next cycle. All counters, timestamp and sticky flags clear on the same edge.
- WARMUP: src_enable=1, measure=0. timestamp increments every cycle in WARMUP, MEASURE and DRAIN; it wraps at 2^24.
  - total_in += popcount(inj_valid).
  - If the pre-update total_in + popcount ≥ WARMUP_PKTS → MEASURE next cycle. Overshoot is allowed.
  - WARMUP_PKTS=0 → MEASURE on the cycle after entering WARMUP.
- MEASURE: src_enable=1, measure=1. meas_cycles increments every cycle.
  - meas_in += popcount(inj_valid). total_in keeps counting.
  - If the new meas_in ≥ MEASURE_PKTS → DRAIN next cycle. Overshoot of up to PORTS-1 is counted and kept.
  - measure drops on the same edge the phase becomes DRAIN. Sources see measure=1 only while phase=MEASURE.
- meas_out += popcount(ej_valid & ej_measure) in MEASURE and DRAIN.
- DRAIN: src_enable=1 to keep background load; measure=0.
  - A drain timer clears on entry and increments each cycle.
  - Exit to DONE when meas_out (post-update) ≥ meas_in.
  - Otherwise exit to DONE when the timer reaches DRAIN_TIMEOUT-1, setting drain_timeout=1.
  - If both conditions hold on the same cycle, completion wins and drain_timeout stays 0.
- DONE: src_enable=0, measure=0, done=1.
  - timestamp and all counters are frozen, and inj/ej inputs are ignored.
  - start=1 → WARMUP with the same clearing as from IDLE.
- start is ignored in WARMUP, MEASURE and DRAIN.
- overflow_err sets on any fifo_error bit in WARMUP, MEASURE or DRAIN, and does not alter sequencing.
- rst mid-run returns to IDLE with all state cleared on the next edge, regardless of the other inputs.

Test Plan (PORTS=4, WARMUP_PKTS=8, MEASURE_PKTS=12, DRAIN_TIMEOUT=20):
- Reset then idle: hold start=0 for 10 cycles → phase=0, timestamp=0, src_enable=0, all counters 0.
- Full run: start pulse, inj_valid=4'b1111 every cycle.
  - Warm-up: WARMUP lasts 2 cycles (total_in=8), then MEASURE.
  - Measurement: MEASURE lasts 3 cycles with measure=1 and meas_cycles=3, meas_in=12, then DRAIN with measure=0.
  - Completion: ejecting 12 measure-tagged packets across 3 cycles gives DONE with done=1, drain_timeout=0, meas_out=12.
- Overshoot: inj_valid=4'b0111 in MEASURE → meas_in reads 3,6,9,12; DRAIN after the 4th cycle. With 4'b1111 after meas_in=9 → meas_in=13, and DRAIN exits only at meas_out≥13.
- Drain timeout: no ejections in DRAIN → DONE exactly 20 cycles after DRAIN entry, drain_timeout=1, meas_out<meas_in.
- Error and start filtering:
  - Pulse fifo_error[2] during WARMUP → overflow_err=1, sticky through DONE, and the phase sequence is unchanged.
  - start pulsed during MEASURE is ignored.
  - start in DONE clears overflow_err and the counters and re-enters WARMUP.
- Reset mid-MEASURE: assert rst with inj_valid=4'b1111 → next cycle phase=0, measure=0, counters=0, timestamp=0.
